atm_account_arbiter: RTL
========================

Name: atm_account_arbiter

Overview:
Shared-resource controller for the ATM account balance store. Several ATM terminal front-ends issue balance, withdraw and deposit transactions. The block round-robin arbitrates these requests and sequences each one as an atomic read-check-write on a single internal balance memory. Each requester gets a done pulse, a status code and the resulting balance, and no two transactions ever interleave.

Parameters:
NUM_REQ, 2, number of terminal requesters (1..8)
NUM_ACC, 10, number of accounts; valid indices 0..NUM_ACC-1 (NUM_ACC <= 16)
BAL_W, 16, balance and amount width in bits
INIT_BAL, 500, balance loaded into every account on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
req  in  NUM_REQ  per-requester request level
req_op  in  2*NUM_REQ  op per requester, slice i = [2i+1:2i]: 00 BALANCE, 01 WITHDRAW, 10 DEPOSIT, 11 reserved
req_acc  in  4*NUM_REQ  account index per requester, slice i = [4i+3:4i]
req_amount  in  BAL_W*NUM_REQ  amount per requester, slice i = [BAL_W*i+BAL_W-1:BAL_W*i]
grant  out  NUM_REQ  one-hot; high for the whole transaction of the winner
done  out  NUM_REQ  one-cycle pulse to the winner when its result is valid
status  out  2  00 OK, 01 INSUFFICIENT, 10 OVERFLOW, 11 BAD_REQ; valid with done
bal_out  out  BAL_W  account balance after the transaction; valid with done

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; grant, done, status and bal_out all 0; round-robin pointer = 0.
  - All NUM_ACC memory entries = INIT_BAL.
  - A transaction in flight is aborted and performs no memory write.
- FSM states: IDLE -> LOAD -> EXEC -> WRITE -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If any req is high, select the winner by round-robin starting at the pointer (lowest index at or after the pointer, wrapping).
  - Latch the winner's op, account and amount; set grant[winner]; go to LOAD. With no req, stay in IDLE.
- LOAD: bal_reg <= mem[acc]. If acc >= NUM_ACC, load 0 and flag bad.
- EXEC: compute the result and status. Priority of checks: BAD_REQ, then op-specific checks.
  - BAD_REQ (11): acc >= NUM_ACC or op = 11. No write; bal_out = 0.
  - BALANCE: OK; new = bal_reg.
  - WITHDRAW: if amount > bal_reg, INSUFFICIENT and new = bal_reg; else OK and new = bal_reg - amount. Withdrawing exactly the full balance is OK and gives 0.
  - DEPOSIT: form the sum in BAL_W+1 bits. On carry out, OVERFLOW and new = bal_reg; else OK and new = sum. Reaching exactly 2^BAL_W-1 is OK.
  - Amount 0 is OK for every op.
- WRITE: mem[acc] <= new only when status is OK and op is WITHDRAW or DEPOSIT.
- RESP: done[winner] = 1 for exactly this cycle; status and bal_out are presented. On exit, grant clears and the pointer moves to winner+1 mod NUM_REQ.
- Latency: req sampled in IDLE at cycle N; grant visible at N+1; done at N+4; grant low at N+5; the next grant no earlier than N+6. Back-to-back throughput is one transaction per 5 cycles.
- Request inputs and deassertion:
  - Operands are captured once in IDLE; later changes are ignored.
  - Dropping req mid-transaction does not abort it; done still pulses.
  - req is level-sensitive: a req still high in IDLE after its done starts a new transaction. Requesters must drop req on done.
- Simultaneous requests: exactly one grant at a time. Losers keep their req high and are served in rotation, so no requester waits more than NUM_REQ-1 transactions.
- Memory has a single port owned by this FSM, so no read/write hazard exists.
- status and bal_out hold their last values between done pulses.

Test Plan:
1. After reset, req[0] with BALANCE on acc 3 -> grant[0] at N+1, done[0] at N+4, status 00, bal_out 500.
2. req[1] WITHDRAW 200 on acc 3, then BALANCE on acc 3 -> bal_out 300 then 300. Then WITHDRAW 300 -> OK, bal_out 0.
3. WITHDRAW 600 on acc 5 (balance 500) -> status 01, bal_out 500. A following BALANCE on acc 5 returns 500.
4. DEPOSIT 65035 on acc 2 -> OK, bal_out 65535. Then DEPOSIT 1 -> status 10, bal_out 65535, memory unchanged.
5. req[0] and req[1] both held high continuously -> grant order 0,1,0,1 with one-hot grants and no overlap. acc 12 or op 11 -> status 11, bal_out 0, no write.
6. Assert rst in the EXEC cycle of a DEPOSIT 100 on acc 1 -> outputs go to 0 immediately. A BALANCE on acc 1 afterwards returns 500.

Source files
------------

// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter: round-robin arbiter that serialises ATM balance,
// withdraw and deposit transactions onto one shared account balance store.
// Each granted transaction runs as an atomic load / execute / write / respond
// sequence, so two terminals can never interleave on the same balance.
module atm_account_arbiter #(
    parameter int          NUM_REQ  = 2,
    parameter int          NUM_ACC  = 10,
    parameter int          BAL_W    = 16,
    parameter int unsigned INIT_BAL = 500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [4*NUM_REQ-1:0]     req_acc,
    input  logic [BAL_W*NUM_REQ-1:0] req_amount,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [1:0]               status,
    output logic [BAL_W-1:0]         bal_out
);

    localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);
    localparam logic [4:0]       NUM_ACC_L = 5'(NUM_ACC);
    localparam logic [BAL_W-1:0] INIT_VAL  = BAL_W'(INIT_BAL);

    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_WD  = 2'b01;
    localparam logic [1:0] OP_DEP = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_INSUF = 2'b01;
    localparam logic [1:0] ST_OVF   = 2'b10;
    localparam logic [1:0] ST_BAD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WRITE,
        S_RESP
    } state_t;

    state_t state;
    state_t next_state;

    // Round-robin pointer and the latched winner of the current transaction
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_sel;
    logic             win_found;
    logic [PTR_W-1:0] win_idx;

    // Operands captured once in IDLE
    logic [1:0]       op_r;
    logic [3:0]       acc_r;
    logic [BAL_W-1:0] amt_r;

    // Working values for the read-check-write sequence
    logic [BAL_W-1:0] bal_reg;
    logic             acc_bad;
    logic [BAL_W-1:0] new_bal;
    logic [1:0]       res_code;
    logic             wr_ok;

    // Balance store and its combinational read port
    logic [BAL_W-1:0] mem [NUM_ACC];
    logic [BAL_W-1:0] rd_data;
    logic             acc_bad_c;

    // Execute-stage results
    logic [BAL_W:0]   sum;
    logic [BAL_W-1:0] exec_bal;
    logic [1:0]       exec_code;
    logic             exec_wr;

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fixed five-step sequence once a winner is chosen
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (win_found) next_state = S_LOAD;
            S_LOAD:  next_state = S_EXEC;
            S_EXEC:  next_state = S_WRITE;
            S_WRITE: next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Pick the first active request at or after the pointer, wrapping around
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_sel   = PTR_W'(idx);
            end
        end
    end

    // Read mux over the balance store; out-of-range accounts read as zero
    always_comb begin
        rd_data   = '0;
        acc_bad_c = ({1'b0, acc_r} >= NUM_ACC_L);
        for (int i = 0; i < NUM_ACC; i++) begin
            if (acc_r == 4'(i)) begin
                rd_data = mem[i];
            end
        end
    end

    // Transaction result: bad requests win over op-specific checks
    always_comb begin
        sum       = {1'b0, bal_reg} + {1'b0, amt_r};
        exec_code = ST_OK;
        exec_bal  = bal_reg;
        exec_wr   = 1'b0;
        if (acc_bad || (op_r == OP_RSV)) begin
            exec_code = ST_BAD;
            exec_bal  = '0;
        end else begin
            case (op_r)
                OP_WD: begin
                    if (amt_r > bal_reg) begin
                        exec_code = ST_INSUF;
                    end else begin
                        exec_bal = bal_reg - amt_r;
                        exec_wr  = 1'b1;
                    end
                end
                OP_DEP: begin
                    if (sum[BAL_W]) begin
                        exec_code = ST_OVF;
                    end else begin
                        exec_bal = sum[BAL_W-1:0];
                        exec_wr  = 1'b1;
                    end
                end
                default: begin
                    exec_code = ST_OK;
                end
            endcase
        end
    end

    // Per-state datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            win_idx  <= '0;
            op_r     <= OP_BAL;
            acc_r    <= '0;
            amt_r    <= '0;
            bal_reg  <= '0;
            acc_bad  <= 1'b0;
            new_bal  <= '0;
            res_code <= ST_OK;
            wr_ok    <= 1'b0;
            grant    <= '0;
            done     <= '0;
            status   <= ST_OK;
            bal_out  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        win_idx          <= win_sel;
                        op_r             <= req_op[2*win_sel +: 2];
                        acc_r            <= req_acc[4*win_sel +: 4];
                        amt_r            <= req_amount[BAL_W*win_sel +: BAL_W];
                        grant            <= '0;
                        grant[win_sel]   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    acc_bad <= acc_bad_c;
                    bal_reg <= acc_bad_c ? '0 : rd_data;
                end
                S_EXEC: begin
                    new_bal  <= exec_bal;
                    res_code <= exec_code;
                    wr_ok    <= exec_wr;
                end
                S_WRITE: begin
                    done          <= '0;
                    done[win_idx] <= 1'b1;
                    status        <= res_code;
                    bal_out       <= new_bal;
                end
                S_RESP: begin
                    done  <= '0;
                    grant <= '0;
                    wr_ok <= 1'b0;
                    ptr   <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
                end
                default: begin
                    done <= '0;
                end
            endcase
        end
    end

    // Balance store: single write port owned by the WRITE step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                mem[i] <= INIT_VAL;
            end
        end else if ((state == S_WRITE) && wr_ok) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (acc_r == 4'(i)) begin
                    mem[i] <= new_bal;
                end
            end
        end
    end

endmodule
